// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
// Shared types and default constants for the traffic phase scheduler.
//   req_state_e : states of the side-street request FSM
//   DEF_*       : default parameter values for the scheduler and its timer
// ----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        REQ_IDLE    = 2'd0,
        REQ_QUAL    = 2'd1,
        REQ_LATCHED = 2'd2,
        REQ_SERVE   = 2'd3
    } req_state_e;

    localparam int unsigned DEF_SHORT_CYC = 4;
    localparam int unsigned DEF_LONG_CYC  = 16;
    localparam int unsigned DEF_DEB_CYC   = 3;
    localparam int unsigned DEF_CNT_W     = 8;

endpackage

// File: rtl/traffic_interval_timer.sv
// ----------------------------------------------------------------------------
// traffic_interval_timer
// Phase interval timer. A start strobe clears the count, which then rises
// one per clock and saturates at LONG_CYC. The short/long expiry flags are
// decoded from the registered count.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   st      : timer start strobe (held high keeps the count at zero)
//   cnt     : current interval count
//   ts      : cnt >= SHORT_CYC
//   tl      : cnt >= LONG_CYC
// ----------------------------------------------------------------------------
module traffic_interval_timer
    import traffic_pkg::*;
#(
    parameter int unsigned SHORT_CYC = DEF_SHORT_CYC,
    parameter int unsigned LONG_CYC  = DEF_LONG_CYC,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             st,
    output logic [CNT_W-1:0] cnt,
    output logic             ts,
    output logic             tl
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturate rather than wrap so the flags stay set until the next start.
    always_comb begin
        cnt_d = cnt_q;
        if (st) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_W'(LONG_CYC)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign ts  = (cnt_q >= CNT_W'(SHORT_CYC));
    assign tl  = (cnt_q >= CNT_W'(LONG_CYC));

endmodule

// File: rtl/traffic_phase_sched.sv
// ----------------------------------------------------------------------------
// traffic_phase_sched
// Sequencing companion for the intersection light controller. Owns the phase
// interval timer and qualifies/latches the side-street car request until the
// side street has been served (side green seen, then released).
//
// Optional build macro: TRAFFIC_PED_REQ_EN adds ped_btn, which latches a
// request immediately from IDLE or QUAL, bypassing the debounce.
//
// Ports:
//   clk         : system clock, rising edge
//   reset_n     : synchronous active-low reset
//   ped_btn     : pedestrian request (only with TRAFFIC_PED_REQ_EN)
//   car_sensor  : raw side-street detector, already synchronised
//   st          : timer start strobe from the controller
//   sg          : side-green indication from the controller
//   c_out       : qualified car request to the controller
//   ts / tl     : short / long interval expired
//   req_pending : request latched and waiting for side green
//   timer_cnt   : current interval count
//
// state   | meaning
// IDLE    | no request, waiting for car_sensor
// QUAL    | counting consecutive high sensor samples
// LATCHED | request held, waiting for side green
// SERVE   | side green active, request held until sg drops
// ----------------------------------------------------------------------------
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int unsigned SHORT_CYC = DEF_SHORT_CYC,
    parameter int unsigned LONG_CYC  = DEF_LONG_CYC,
    parameter int unsigned DEB_CYC   = DEF_DEB_CYC,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef TRAFFIC_PED_REQ_EN
    input  logic             ped_btn,
`endif
    input  logic             car_sensor,
    input  logic             st,
    input  logic             sg,
    output logic             c_out,
    output logic             ts,
    output logic             tl,
    output logic             req_pending,
    output logic [CNT_W-1:0] timer_cnt
);

    localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);

    req_state_e       state_q;
    logic [DEB_W-1:0] deb_q;
    logic             c_out_q;
    logic             req_pending_q;
    logic             ped_hit;

`ifdef TRAFFIC_PED_REQ_EN
    assign ped_hit = ped_btn;
`else
    assign ped_hit = 1'b0;
`endif

    traffic_interval_timer #(
        .SHORT_CYC (SHORT_CYC),
        .LONG_CYC  (LONG_CYC),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .st      (st),
        .cnt     (timer_cnt),
        .ts      (ts),
        .tl      (tl)
    );

    // Outputs are assigned alongside each transition so they reflect the
    // state being entered, giving one cycle from the final sample to c_out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= REQ_IDLE;
            deb_q         <= '0;
            c_out_q       <= 1'b0;
            req_pending_q <= 1'b0;
        end else begin
            case (state_q)
                REQ_IDLE, REQ_QUAL: begin
                    if (ped_hit ||
                        (car_sensor && (state_q == REQ_IDLE) && (DEB_CYC == 1)) ||
                        (car_sensor && (state_q == REQ_QUAL) &&
                         (deb_q + DEB_W'(1) >= DEB_W'(DEB_CYC)))) begin
                        state_q       <= REQ_LATCHED;
                        deb_q         <= '0;
                        c_out_q       <= 1'b1;
                        req_pending_q <= 1'b1;
                    end else if (car_sensor) begin
                        state_q       <= REQ_QUAL;
                        deb_q         <= (state_q == REQ_IDLE) ? DEB_W'(1) : deb_q + DEB_W'(1);
                        c_out_q       <= 1'b0;
                        req_pending_q <= 1'b0;
                    end else begin
                        state_q       <= REQ_IDLE;
                        deb_q         <= '0;
                        c_out_q       <= 1'b0;
                        req_pending_q <= 1'b0;
                    end
                end
                REQ_LATCHED: begin
                    c_out_q <= 1'b1;
                    if (sg) begin
                        state_q       <= REQ_SERVE;
                        req_pending_q <= 1'b0;
                    end else begin
                        req_pending_q <= 1'b1;
                    end
                end
                REQ_SERVE: begin
                    req_pending_q <= 1'b0;
                    if (sg) begin
                        c_out_q <= 1'b1;
                    end else if (car_sensor && (DEB_CYC == 1)) begin
                        // Re-request already satisfies a single-sample debounce.
                        state_q       <= REQ_LATCHED;
                        c_out_q       <= 1'b1;
                        req_pending_q <= 1'b1;
                    end else if (car_sensor) begin
                        state_q <= REQ_QUAL;
                        deb_q   <= DEB_W'(1);
                        c_out_q <= 1'b0;
                    end else begin
                        state_q <= REQ_IDLE;
                        deb_q   <= '0;
                        c_out_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= REQ_IDLE;
                    deb_q         <= '0;
                    c_out_q       <= 1'b0;
                    req_pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign c_out       = c_out_q;
    assign req_pending = req_pending_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// ----------------------------------------------------------------------------
// tb_traffic_phase_sched
// Directed scoreboard bench for traffic_phase_sched with default parameters.
// The driver advances one clock at a time and queues the outputs expected
// after that edge; a monitor pops and compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_traffic_phase_sched;

    localparam int unsigned CNT_W = 8;

    // mask bits: 0 c_out, 1 ts, 2 tl, 3 req_pending, 4 timer_cnt
    localparam logic [4:0] M_ALL = 5'b11111;
    localparam logic [4:0] M_REQ = 5'b01001;
    localparam logic [4:0] M_TIM = 5'b10110;

    typedef struct {
        string      name;
        logic [4:0] mask;
        logic       c;
        logic       ts;
        logic       tl;
        logic       rp;
        logic [7:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             car_sensor;
    logic             st;
    logic             sg;
`ifdef TRAFFIC_PED_REQ_EN
    logic             ped_btn;
`endif
    logic             c_out;
    logic             ts;
    logic             tl;
    logic             req_pending;
    logic [CNT_W-1:0] timer_cnt;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    traffic_phase_sched dut (
        .clk         (clk),
        .reset_n     (reset_n),
`ifdef TRAFFIC_PED_REQ_EN
        .ped_btn     (ped_btn),
`endif
        .car_sensor  (car_sensor),
        .st          (st),
        .sg          (sg),
        .c_out       (c_out),
        .ts          (ts),
        .tl          (tl),
        .req_pending (req_pending),
        .timer_cnt   (timer_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [4:0] mask,
                              input logic c, input logic t_s, input logic t_l,
                              input logic rp, input int cnt);
        exp_t e;
        e.name = name;
        e.mask = mask;
        e.c    = c;
        e.ts   = t_s;
        e.tl   = t_l;
        e.rp   = rp;
        e.cnt  = 8'(cnt);
        exp_q.push_back(e);
    endtask

    // Monitor: compares every queued expectation at the next falling edge.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                bad = 1'b0;
                n_vec++;
                if (e.mask[0] && c_out !== e.c) begin
                    bad = 1'b1;
                    $display("FAIL %s c_out got %b exp %b", e.name, c_out, e.c);
                end
                if (e.mask[1] && ts !== e.ts) begin
                    bad = 1'b1;
                    $display("FAIL %s ts got %b exp %b", e.name, ts, e.ts);
                end
                if (e.mask[2] && tl !== e.tl) begin
                    bad = 1'b1;
                    $display("FAIL %s tl got %b exp %b", e.name, tl, e.tl);
                end
                if (e.mask[3] && req_pending !== e.rp) begin
                    bad = 1'b1;
                    $display("FAIL %s req_pending got %b exp %b", e.name, req_pending, e.rp);
                end
                if (e.mask[4] && timer_cnt !== e.cnt) begin
                    bad = 1'b1;
                    $display("FAIL %s timer_cnt got %0d exp %0d", e.name, timer_cnt, e.cnt);
                end
                if (bad) n_bad++;
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        car_sensor = 1'b1;
        st         = 1'b1;
        sg         = 1'b0;
`ifdef TRAFFIC_PED_REQ_EN
        ped_btn    = 1'b0;
`endif

        // Reset held two cycles with sensor and start active.
        tick(); expect_out("rst_c1", M_ALL, 0, 0, 0, 0, 0);
        tick(); expect_out("rst_c2", M_ALL, 0, 0, 0, 0, 0);
        reset_n    = 1'b1;
        car_sensor = 1'b0;
        st         = 1'b0;
        expect_out("rst_rel", M_ALL, 0, 0, 0, 0, 0);

        // Timer: single start pulse, then free-run to saturation.
        tick();
        st = 1'b1;
        tick(); expect_out("tim_start", M_ALL, 0, 0, 0, 0, 0);
        st = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            expect_out($sformatf("tim_k%0d", k), M_TIM, 0,
                       (k >= 4), (k >= 16), 0, (k >= 16) ? 16 : k);
        end
        st = 1'b1;
        tick(); expect_out("tim_restart", M_TIM, 0, 0, 0, 0, 0);
        tick(); expect_out("tim_hold1", M_TIM, 0, 0, 0, 0, 0);
        st = 1'b0;
        tick(); expect_out("tim_run1", M_TIM, 0, 0, 0, 0, 1);
        for (int k = 2; k <= 4; k++) tick();
        expect_out("tim_ts4", M_TIM, 0, 1, 0, 0, 4);

        // Debounce glitch: two high samples are not enough.
        car_sensor = 1'b1;
        tick(); expect_out("deb_g1", M_REQ, 0, 0, 0, 0, 0);
        tick(); expect_out("deb_g2", M_REQ, 0, 0, 0, 0, 0);
        car_sensor = 1'b0;
        tick(); expect_out("deb_g_drop", M_REQ, 0, 0, 0, 0, 0);
        tick(); expect_out("deb_g_idle", M_REQ, 0, 0, 0, 0, 0);

        // Three consecutive samples latch the request.
        car_sensor = 1'b1;
        tick(); expect_out("deb_s1", M_REQ, 0, 0, 0, 0, 0);
        tick(); expect_out("deb_s2", M_REQ, 0, 0, 0, 0, 0);
        tick(); expect_out("deb_s3", M_REQ, 1, 0, 0, 1, 0);

        // Latch hold with sensor low; an st pulse must not disturb it.
        car_sensor = 1'b0;
        for (int k = 0; k < 30; k++) begin
            st = (k == 10);
            tick();
            expect_out($sformatf("hold_%0d", k), M_REQ, 1, 0, 0, 1, 0);
        end
        st = 1'b0;
        sg = 1'b1;
        tick(); expect_out("serve_enter", M_REQ, 1, 0, 0, 0, 0);
        tick(); expect_out("serve_hold", M_REQ, 1, 0, 0, 0, 0);
        sg = 1'b0;
        tick(); expect_out("serve_exit", M_REQ, 0, 0, 0, 0, 0);

        // Re-request from SERVE.
        car_sensor = 1'b1;
        tick(); tick(); tick();
        expect_out("rr_latch", M_REQ, 1, 0, 0, 1, 0);
        sg = 1'b1;
        tick(); expect_out("rr_serve", M_REQ, 1, 0, 0, 0, 0);
        sg = 1'b0;
        tick(); expect_out("rr_qual1", M_REQ, 0, 0, 0, 0, 0);
        tick(); expect_out("rr_qual2", M_REQ, 0, 0, 0, 0, 0);
        tick(); expect_out("rr_relatch", M_REQ, 1, 0, 0, 1, 0);

        // Reset mid-operation discards the latched request.
        car_sensor = 1'b0;
        reset_n    = 1'b0;
        tick(); expect_out("rst_mid", M_ALL, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        tick(); expect_out("rst_mid_rel", M_REQ, 0, 0, 0, 0, 0);

`ifdef TRAFFIC_PED_REQ_EN
        // Pedestrian button bypasses debounce from IDLE, ignored in SERVE.
        ped_btn = 1'b1;
        tick(); expect_out("ped_latch", M_REQ, 1, 0, 0, 1, 0);
        ped_btn = 1'b0;
        sg = 1'b1;
        tick(); expect_out("ped_serve", M_REQ, 1, 0, 0, 0, 0);
        ped_btn = 1'b1;
        tick(); expect_out("ped_in_serve", M_REQ, 1, 0, 0, 0, 0);
        ped_btn = 1'b0;
        sg = 1'b0;
        tick(); expect_out("ped_release", M_REQ, 0, 0, 0, 0, 0);
`endif

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain queue got %0d pending exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
